serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 104 ++++++++++
 tb/tb_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// Parallel-to-serial word converter.
// Captures an INPUT_WIDTH-bit word on a start request and presents it as
// NUM_WORDS = INPUT_WIDTH/OUTPUT_WIDTH consecutive OUTPUT_WIDTH-bit words,
// most-significant word first, one word per clock.
//
// Ports:
//   clk                - clock, all state changes on rising edge
//   reset_n            - asynchronous reset, ACTIVE HIGH despite the name
//   start_serialize    - capture input_data and begin output (ignored while busy)
//   input_data         - parallel word to serialize
//   output_data        - current serial word (0 when not valid)
//   output_valid       - high while output_data carries a word
//   serialization_done - one-cycle pulse coincident with the last word
//
// INPUT_WIDTH must be a multiple of OUTPUT_WIDTH with at least two words.
module serializer #(
   parameter int unsigned INPUT_WIDTH  = 256,
   parameter int unsigned OUTPUT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start_serialize,
   input  logic [INPUT_WIDTH-1:0]  input_data,
   output logic [OUTPUT_WIDTH-1:0] output_data,
   output logic                    output_valid,
   output logic                    serialization_done
);

   localparam int unsigned NumWords = INPUT_WIDTH / OUTPUT_WIDTH;
   localparam int unsigned CntW     = $clog2(NumWords);
   localparam logic [CntW-1:0] LastCnt   = CntW'(NumWords - 1);
   localparam logic [CntW-1:0] PenultCnt = CntW'(NumWords - 2);

   typedef enum logic {StIdle, StShift} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   // Holds the words not yet presented, left-aligned so the next word is
   // always the top OUTPUT_WIDTH bits.
   logic [INPUT_WIDTH-1:0]  shift_q, shift_d;
   logic [OUTPUT_WIDTH-1:0] data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_serialize) begin
               state_d = StShift;
               cnt_d   = '0;
               data_d  = input_data[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
               shift_d = input_data << OUTPUT_WIDTH;
               valid_d = 1'b1;
            end
         end
         StShift: begin
            // cnt_q is the index of the word currently on output_data.
            if (cnt_q == LastCnt) begin
               state_d = StIdle;
               cnt_d   = '0;
               shift_d = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               data_d  = shift_q[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
               shift_d = shift_q << OUTPUT_WIDTH;
               valid_d = 1'b1;
               done_d  = (cnt_q == PenultCnt);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign output_data        = data_q;
   assign output_valid       = valid_q;
   assign serialization_done = done_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a default 256/16 instance and a 64/8
// override instance, each with a cycle-level reference model that pushes
// expected words into a queue at capture and a monitor that pops them.
module tb_serializer;

   localparam int unsigned IW_A = 256;
   localparam int unsigned OW_A = 16;
   localparam int unsigned NW_A = IW_A / OW_A;
   localparam int unsigned IW_B = 64;
   localparam int unsigned OW_B = 8;
   localparam int unsigned NW_B = IW_B / OW_B;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            start_a, start_b;
   logic [IW_A-1:0] din_a;
   logic [IW_B-1:0] din_b;
   logic [OW_A-1:0] dout_a;
   logic [OW_B-1:0] dout_b;
   logic            valid_a, valid_b, done_a, done_b;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   int   busy_a = 0;
   int   busy_b = 0;

   serializer dut_a (
      .clk                (clk),
      .reset_n            (rst),
      .start_serialize    (start_a),
      .input_data         (din_a),
      .output_data        (dout_a),
      .output_valid       (valid_a),
      .serialization_done (done_a)
   );

   serializer #(
      .INPUT_WIDTH  (IW_B),
      .OUTPUT_WIDTH (OW_B)
   ) dut_b (
      .clk                (clk),
      .reset_n            (rst),
      .start_serialize    (start_b),
      .input_data         (din_b),
      .output_data        (dout_b),
      .output_valid       (valid_b),
      .serialization_done (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a capture happens only at an edge where the model is idle.
   always @(posedge clk) begin
      if (!rst) begin
         if (busy_a == 0) begin
            if (start_a) begin
               for (int w = 0; w < int'(NW_A); w++) begin
                  exp_t e;
                  e.data = din_a[IW_A-1-w*OW_A -: OW_A];
                  e.last = (w == int'(NW_A) - 1);
                  q_a.push_back(e);
               end
               busy_a = NW_A;
            end
         end else begin
            busy_a--;
         end
         if (busy_b == 0) begin
            if (start_b) begin
               for (int w = 0; w < int'(NW_B); w++) begin
                  exp_t e;
                  e.data = {8'h00, din_b[IW_B-1-w*OW_B -: OW_B]};
                  e.last = (w == int'(NW_B) - 1);
                  q_b.push_back(e);
               end
               busy_b = NW_B;
            end
         end else begin
            busy_b--;
         end
      end
   end

   always @(posedge rst) begin
      q_a.delete();
      q_b.delete();
      busy_a = 0;
      busy_b = 0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         exp_t e;
         check("valid_a", valid_a, q_a.size() != 0);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("data_a", dout_a, e.data);
            check("done_a", done_a, e.last);
         end else begin
            check("idle_data_a", dout_a, 0);
            check("idle_done_a", done_a, 0);
         end
         check("valid_b", valid_b, q_b.size() != 0);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("data_b", dout_b, e.data);
            check("done_b", done_b, e.last);
         end else begin
            check("idle_data_b", dout_b, 0);
            check("idle_done_b", done_b, 0);
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_din_a();
      for (int i = 0; i < 8; i++) din_a[i*32 +: 32] = $urandom();
   endtask

   localparam logic [IW_A-1:0] PatA = {4{64'h0123456789ABCDEF}};
   localparam logic [IW_A-1:0] PatB = {4{64'hFEDCBA9876543210}};

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      din_a   = '0;
      din_b   = '0;
      #1;
      check("rst_data", dout_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_done", done_a, 0);
      tick(3);
      rst = 1'b0;
      tick(2);

      // MSW-first sequence on both instances, with one-clock latency.
      din_a   = PatA;
      din_b   = 64'h0011223344556677;
      start_a = 1'b1;
      start_b = 1'b1;
      tick(1);
      start_a = 1'b0;
      start_b = 1'b0;
      check("first_word_a", dout_a, 16'h0123);
      check("first_word_b", dout_b, 8'h00);
      tick(1);
      check("second_word_a", dout_a, 16'h4567);
      tick(20);

      din_a   = PatB;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      check("first_word_pat_b", dout_a, 16'hFEDC);
      tick(20);

      // Start held mid-serialization and input changed after capture.
      din_a   = PatA;
      start_a = 1'b1;
      tick(1);
      din_a = PatB;
      tick(4);
      start_a = 1'b0;
      rand_din_a();
      tick(16);

      // Asynchronous reset mid-serialization, off the clock edge.
      din_a   = PatB;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      tick(4);
      #3;
      rst = 1'b1;
      start_a = 1'b1;
      #1;
      check("abort_data", dout_a, 0);
      check("abort_valid", valid_a, 0);
      check("abort_done", done_a, 0);
      tick(2);
      check("hold_rst_valid", valid_a, 0);
      start_a = 1'b0;
      rst     = 1'b0;
      tick(2);
      din_a   = PatA;
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      tick(20);

      // Continuous start: back-to-back bursts with one idle cycle between.
      start_a = 1'b1;
      start_b = 1'b1;
      for (int c = 0; c < 60; c++) begin
         rand_din_a();
         din_b = {$urandom(), $urandom()};
         tick(1);
      end
      start_a = 1'b0;
      start_b = 1'b0;
      tick(20);

      check("drain_a", q_a.size(), 0);
      check("drain_b", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
